bcd_stopwatch_counter: RTL and testbench

Two-digit BCD stopwatch/timer core feeding the `seg7_control` display driver on the edge Spartan-6 board. It debounces two push-buttons, runs a start/pause/clear state machine, divides the 50 MHz clock down to a count tick, and maintains a wrap-around BCD count (`tens`:`ones`). It counts up or down and never presents a non-BCD digit, because the downstream decoder has no default decode.

---
 rtl/bcd_stopwatch_counter.sv | 183 ++++++++++++++++++
 tb/tb_bcd_stopwatch_counter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_counter.sv
// Two-digit BCD stopwatch core: button debounce, start/pause/clear FSM,
// tick prescaler and wrap-around up/down BCD count for a seg7 driver.

module bcd_sw_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          acc_q, acc_d;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle matching the accepted level restarts the stability count.
    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (sync2_q != acc_q) begin
            if (cnt_q == CW'(CYCLES - 1))
                acc_d = sync2_q;
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            press_q <= acc_d & ~acc_q;
        end
    end

    assign press_o = press_q;
endmodule

module bcd_stopwatch_counter #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_COUNT       = 59
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       up_down,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       wrap_pulse
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

    state_e        state_q, state_d;
    logic          ss_press, clr_press;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d;
    logic          wrap_q, wrap_d;
    logic          tick, at_max, at_zero;

    bcd_sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
        .clk_i  (clk_50MHz),
        .rst_ni (reset),
        .btn_i  (btn_start_stop),
        .press_o(ss_press)
    );

    bcd_sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk_i  (clk_50MHz),
        .rst_ni (reset),
        .btn_i  (btn_clear),
        .press_o(clr_press)
    );

    always_ff @(posedge clk_50MHz) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Clear outranks start/stop when both pulse together.
    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = S_IDLE;
        end else if (ss_press) begin
            unique case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state_q == S_RUN);
    end

    assign tick    = running && (pre_q == PW'(DIV - 1));
    assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        pre_d  = pre_q;
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (clr_press) begin
            pre_d  = '0;
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else begin
            if (state_q == S_IDLE)
                pre_d = '0;
            else if (running)
                pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                if (up_down) begin
                    if (at_max) begin
                        ones_d = 4'd0;
                        tens_d = 4'd0;
                        wrap_d = 1'b1;
                    end else if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    if (at_zero) begin
                        ones_d = MAX_O;
                        tens_d = MAX_T;
                        wrap_d = 1'b1;
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            pre_q  <= '0;
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
            wrap_q <= wrap_d;
        end
    end

    assign ones       = ones_q;
    assign tens       = tens_q;
    assign wrap_pulse = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Bench for bcd_stopwatch_counter: integer-count reference model checked
// every cycle, directed timing pins, then randomized button activity.

module tb_bcd_stopwatch_counter;
    localparam int DIV  = 20;
    localparam int DEB  = 4;
    localparam int MAXC = 59;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_ss = 1'b0;
    logic       b_clr = 1'b0;
    logic       up = 1'b1;
    logic [3:0] ones, tens;
    logic       running, wrap;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bcd_stopwatch_counter #(
        .CLK_HZ(20),
        .TICK_HZ(1),
        .DEBOUNCE_CYCLES(DEB),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk_50MHz(clk),
        .reset(rst_n),
        .btn_start_stop(b_ss),
        .btn_clear(b_clr),
        .up_down(up),
        .ones(ones),
        .tens(tens),
        .running(running),
        .wrap_pulse(wrap)
    );

    // Model: state 0 idle, 1 run, 2 pause; count kept as a plain integer.
    int m_state = 0;
    int m_cnt = 0;
    int m_rc = 0;
    bit m_wrap = 1'b0;
    bit h1[2];
    bit h2[2];
    bit acc[2];
    bit pend[2];
    int runlen[2];

    always @(posedge clk) begin
        bit raw[2];
        bit f_ss, f_clr, lvl;
        raw[0] = b_ss;
        raw[1] = b_clr;
        if (!rst_n) begin
            m_state = 0;
            m_cnt = 0;
            m_rc = 0;
            m_wrap = 1'b0;
            for (int b = 0; b < 2; b++) begin
                h1[b] = 1'b0;
                h2[b] = 1'b0;
                acc[b] = 1'b0;
                pend[b] = 1'b0;
                runlen[b] = 0;
            end
        end else begin
            f_ss = pend[0];
            f_clr = pend[1];
            for (int b = 0; b < 2; b++) begin
                pend[b] = 1'b0;
                lvl = h2[b];
                h2[b] = h1[b];
                h1[b] = raw[b];
                if (lvl != acc[b]) begin
                    runlen[b]++;
                    if (runlen[b] == DEB) begin
                        acc[b] = lvl;
                        runlen[b] = 0;
                        pend[b] = lvl;
                    end
                end else begin
                    runlen[b] = 0;
                end
            end
            m_wrap = 1'b0;
            if (f_clr) begin
                m_state = 0;
                m_cnt = 0;
                m_rc = 0;
            end else begin
                if (m_state == 1) begin
                    m_rc++;
                    if (m_rc == DIV) begin
                        m_rc = 0;
                        if (up) begin
                            m_wrap = (m_cnt == MAXC);
                            m_cnt = m_wrap ? 0 : m_cnt + 1;
                        end else begin
                            m_wrap = (m_cnt == 0);
                            m_cnt = m_wrap ? MAXC : m_cnt - 1;
                        end
                    end
                end
                if (f_ss)
                    m_state = (m_state == 1) ? 2 : 1;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int cnt();
        return int'(tens) * 10 + int'(ones);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_running", int'(running), int'(m_state == 1));
            check("m_ones", int'(ones), m_cnt % 10);
            check("m_tens", int'(tens), m_cnt / 10);
            check("m_wrap", int'(wrap), int'(m_wrap));
        end
    end

    task automatic wait_val(input int t, input int o, input int bound);
        int k = 0;
        while (!(int'(tens) == t && int'(ones) == o) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("reach", cnt(), t * 10 + o);
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_ss = ~b_ss;
            b_clr = b_ss ^ 1'b1;
            @(negedge clk);
            check("reset_out", int'({running, wrap, tens, ones}), 0);
        end
        b_ss = 1'b0;
        b_clr = 1'b0;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_hold", int'({running, wrap, tens, ones}), 0);

        b_ss = 1'b1;
        repeat (3) @(negedge clk);
        b_ss = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch", int'(running), 0);

        b_ss = 1'b1;
        repeat (6) @(negedge clk);
        check("deb_early", int'(running), 0);
        @(negedge clk);
        check("deb_run", int'(running), 1);
        repeat (3) @(negedge clk);
        b_ss = 1'b0;
        repeat (16) @(negedge clk);
        check("first_hold", cnt(), 0);
        @(negedge clk);
        check("first_tick", cnt(), 1);

        wait_val(0, 9, 400);
        repeat (20) @(negedge clk);
        check("carry", cnt(), 10);

        wait_val(5, 9, 1200);
        repeat (19) @(negedge clk);
        check("pre_wrap_cnt", cnt(), 59);
        check("pre_wrap_pulse", int'(wrap), 0);
        @(negedge clk);
        check("wrap_cnt", cnt(), 0);
        check("wrap_pulse", int'(wrap), 1);
        up = 1'b0;
        @(negedge clk);
        check("wrap_width", int'(wrap), 0);
        repeat (19) @(negedge clk);
        check("down_wrap_cnt", cnt(), 59);
        check("down_wrap_pulse", int'(wrap), 1);
        repeat (20) @(negedge clk);
        check("down_58", cnt(), 58);
        check("down_58_pulse", int'(wrap), 0);

        wait_val(1, 0, 1200);
        repeat (20) @(negedge clk);
        check("borrow", cnt(), 9);

        b_ss = 1'b1;
        repeat (6) @(negedge clk);
        check("pause_early", int'(running), 1);
        @(negedge clk);
        check("paused", int'(running), 0);
        repeat (3) @(negedge clk);
        b_ss = 1'b0;
        repeat (200) @(negedge clk);
        check("pause_frozen", cnt(), 9);
        b_ss = 1'b1;
        repeat (7) @(negedge clk);
        check("resumed", int'(running), 1);
        repeat (3) @(negedge clk);
        b_ss = 1'b0;
        repeat (9) @(negedge clk);
        check("resume_hold", cnt(), 9);
        @(negedge clk);
        check("resume_tick", cnt(), 8);

        up = 1'b1;
        wait_val(3, 7, 1000);
        b_clr = 1'b1;
        repeat (7) @(negedge clk);
        check("clear_cnt", cnt(), 0);
        check("clear_run", int'(running), 0);
        repeat (3) @(negedge clk);
        b_clr = 1'b0;
        repeat (10) @(negedge clk);

        b_ss = 1'b1;
        b_clr = 1'b1;
        repeat (10) @(negedge clk);
        b_ss = 1'b0;
        b_clr = 1'b0;
        repeat (40) @(negedge clk);
        check("both_run", int'(running), 0);
        check("both_cnt", cnt(), 0);

        b_ss = 1'b1;
        repeat (10) @(negedge clk);
        b_ss = 1'b0;
        wait_val(0, 2, 200);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_cnt", cnt(), 0);
        check("rst_run", int'(running), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        repeat (5000) begin
            if ($urandom_range(0, 7) == 0) b_ss = ~b_ss;
            if ($urandom_range(0, 63) == 0) b_clr = ~b_clr;
            if ($urandom_range(0, 63) == 0) up = ~up;
            rst_n = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
